// File: rtl/ahb_slave_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ahb_slave_port_arbiter_if                                     |
// | Purpose  : Bundles the request/transfer inputs and the grant/ownership   |
// |            outputs of one AHB slave-port arbiter.                        |
// | Signals  : req        [N]    master m requests this slave                |
// |            htrans     [2N]   per-master htrans, m at [2m+1:2m]           |
// |            hmastlock  [N]    per-master lock                             |
// |            hready            slave hreadyout                             |
// |            grant      [N]    one-hot address-phase owner (registered)    |
// |            addr_owner [W]    encoded grant                               |
// |            owner_valid       grant is non-zero                           |
// |            data_owner [W]    master whose data phase is active           |
// |            data_valid        a data phase is in progress                 |
// |            locked            arbiter is in LOCKED state                  |
// |            lock_timeout      sticky lock-hold error                      |
// | Modports : slave  - arbiter side; master - interconnect side             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ahb_slave_port_arbiter_if #(
  parameter int NO_OF_MASTERS = 4
);
  localparam int IDX_W = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;

  logic [NO_OF_MASTERS-1:0]   req;
  logic [2*NO_OF_MASTERS-1:0] htrans;
  logic [NO_OF_MASTERS-1:0]   hmastlock;
  logic                       hready;
  logic [NO_OF_MASTERS-1:0]   grant;
  logic [IDX_W-1:0]           addr_owner;
  logic                       owner_valid;
  logic [IDX_W-1:0]           data_owner;
  logic                       data_valid;
  logic                       locked;
  logic                       lock_timeout;

  modport slave (
    input  req, htrans, hmastlock, hready,
    output grant, addr_owner, owner_valid, data_owner, data_valid, locked, lock_timeout
  );

  modport master (
    output req, htrans, hmastlock, hready,
    input  grant, addr_owner, owner_valid, data_owner, data_valid, locked, lock_timeout
  );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ahb_slave_port_arbiter                                        |
// | Purpose  : Per-slave-port round-robin arbiter and sequencer for an AHB   |
// |            multi-master interconnect. Issues a registered one-hot        |
// |            address-phase grant, tracks the data-phase owner, holds the   |
// |            bus through bursts and locked sequences, and only changes     |
// |            ownership on hready-qualified edges.                          |
// | Ports    : hclk    - clock                                               |
// |            hreset  - synchronous active-high reset                       |
// |            bus     - ahb_slave_port_arbiter_if.slave (req/htrans/        |
// |                      hmastlock/hready in; grant/owner/data/lock out)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ahb_slave_port_arbiter #(
  parameter int NO_OF_MASTERS = 4,
  parameter int LOCK_TIMEOUT  = 64
) (
  input wire                      hclk,
  input wire                      hreset,
  ahb_slave_port_arbiter_if.slave bus
);

  localparam int IDX_W = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [1:0]       c_HT_BUSY   = 2'b01;
  localparam logic [1:0]       c_HT_NONSEQ = 2'b10;
  localparam logic [1:0]       c_HT_SEQ    = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OWNED  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  logic [NO_OF_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]         r_addr_owner;
  logic                     r_owner_valid;
  logic [IDX_W-1:0]         r_data_owner;
  logic                     r_data_valid;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic [CNT_W-1:0]         r_lock_cnt;
  logic                     r_lock_timeout;

  logic [1:0]               w_htrans_m [NO_OF_MASTERS];
  logic [1:0]               w_own_htrans;
  logic                     w_own_lock;
  logic                     w_hold;
  logic                     w_req_found;
  logic [IDX_W-1:0]         w_req_idx;
  logic                     w_lock_found;
  logic [IDX_W-1:0]         w_lock_idx;
  logic [IDX_W-1:0]         w_next_idx;
  logic                     w_next_valid;
  logic                     w_ptr_upd;

  // (base + off) mod NO_OF_MASTERS, valid for non-power-of-two master counts
  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = 32'(base);
    s = s + off;
    if (s >= NO_OF_MASTERS) s = s - NO_OF_MASTERS;
    return IDX_W'(s);
  endfunction

  generate
    for (genvar m = 0; m < NO_OF_MASTERS; m++) begin : g_split
      assign w_htrans_m[m] = bus.htrans[2*m +: 2];
    end
  endgenerate

  assign w_own_htrans = w_htrans_m[r_addr_owner];
  assign w_own_lock   = bus.hmastlock[r_addr_owner];

  // Hold is judged on the owner's htrans/lock, never on its req, so a burst
  // survives the master dropping req while it still drives SEQ/BUSY.
  assign w_hold = (r_state != S_IDLE) &&
                  ((w_own_htrans == c_HT_SEQ) || (w_own_htrans == c_HT_BUSY) || w_own_lock);

  // Round-robin scans from rr_ptr with wrap; locked requesters are searched
  // separately so they can take priority over plain ones.
  always_comb begin
    w_req_found  = 1'b0;
    w_req_idx    = '0;
    w_lock_found = 1'b0;
    w_lock_idx   = '0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      if (!w_req_found && bus.req[f_wrap(r_rr_ptr, i)]) begin
        w_req_found = 1'b1;
        w_req_idx   = f_wrap(r_rr_ptr, i);
      end
      if (!w_lock_found && bus.req[f_wrap(r_rr_ptr, i)] && bus.hmastlock[f_wrap(r_rr_ptr, i)]) begin
        w_lock_found = 1'b1;
        w_lock_idx   = f_wrap(r_rr_ptr, i);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_addr_owner;
    w_next_valid = r_owner_valid;
    w_ptr_upd    = 1'b0;
    if (bus.hready) begin
      if (w_hold) begin
        // Once LOCKED, only a full release (no lock, no SEQ/BUSY) leaves it.
        w_next_valid = 1'b1;
        w_next_state = ((r_state == S_LOCKED) || w_own_lock) ? S_LOCKED : S_OWNED;
      end else if (w_lock_found) begin
        w_next_idx   = w_lock_idx;
        w_next_valid = 1'b1;
        w_next_state = S_LOCKED;
        w_ptr_upd    = 1'b1;
      end else if (w_req_found) begin
        w_next_idx   = w_req_idx;
        w_next_valid = 1'b1;
        w_next_state = S_OWNED;
        w_ptr_upd    = 1'b1;
      end else begin
        w_next_idx   = '0;
        w_next_valid = 1'b0;
        w_next_state = S_IDLE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_addr_owner  <= '0;
      r_owner_valid <= 1'b0;
      r_rr_ptr      <= '0;
      r_data_owner  <= '0;
      r_data_valid  <= 1'b0;
    end else if (bus.hready) begin
      r_state       <= w_next_state;
      r_grant       <= w_next_valid ? (NO_OF_MASTERS'(1) << w_next_idx) : '0;
      r_addr_owner  <= w_next_idx;
      r_owner_valid <= w_next_valid;
      if (w_ptr_upd) begin
        r_rr_ptr <= f_wrap(w_next_idx, 1);
      end
      // Address phase completing now becomes the active data phase.
      if (r_owner_valid && ((w_own_htrans == c_HT_NONSEQ) || (w_own_htrans == c_HT_SEQ))) begin
        r_data_owner <= r_addr_owner;
        r_data_valid <= 1'b1;
      end else begin
        r_data_valid <= 1'b0;
      end
    end
  end

  // Counts edges spent in LOCKED; the entry edge itself is not counted.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_lock_cnt     <= '0;
      r_lock_timeout <= 1'b0;
    end else if (w_next_state != S_LOCKED) begin
      r_lock_cnt <= '0;
    end else if (r_state == S_LOCKED) begin
      if (r_lock_cnt < c_CNT_MAX) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
      if (r_lock_cnt >= (c_CNT_MAX - 1'b1)) begin
        r_lock_timeout <= 1'b1;
      end
    end
  end

  assign bus.grant        = r_grant;
  assign bus.addr_owner   = r_addr_owner;
  assign bus.owner_valid  = r_owner_valid;
  assign bus.data_owner   = r_data_owner;
  assign bus.data_valid   = r_data_valid;
  assign bus.locked       = (r_state == S_LOCKED);
  assign bus.lock_timeout = r_lock_timeout;

endmodule
`default_nettype wire
